// File: rtl/tpg_pkg.sv
// tpg_pkg: shared types and default LFSR feedback masks for the test pattern generator.
package tpg_pkg;
  typedef enum logic [1:0] {TPG_LFSR, TPG_COUNT, TPG_WALK1, TPG_WALK0} tpg_mode_e;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} tpg_state_e;
  // Maximal-length masks for next = {s[n-2:0], ^(s & taps)}; bit k-1 set for tap k.
  function automatic logic [31:0] default_taps(input int n);
    logic [31:0] t;
    case (n)
      3:  t = 32'h0000_0006;
      4:  t = 32'h0000_000C;
      5:  t = 32'h0000_0014;
      6:  t = 32'h0000_0030;
      7:  t = 32'h0000_0060;
      8:  t = 32'h0000_00B8;
      9:  t = 32'h0000_0110;
      10: t = 32'h0000_0240;
      11: t = 32'h0000_0500;
      12: t = 32'h0000_0829;
      13: t = 32'h0000_100D;
      14: t = 32'h0000_2015;
      15: t = 32'h0000_6000;
      16: t = 32'h0000_D008;
      17: t = 32'h0001_2000;
      18: t = 32'h0002_0400;
      19: t = 32'h0004_0023;
      20: t = 32'h0009_0000;
      21: t = 32'h0014_0000;
      22: t = 32'h0030_0000;
      23: t = 32'h0042_0000;
      24: t = 32'h00E1_0000;
      25: t = 32'h0120_0000;
      26: t = 32'h0200_0023;
      27: t = 32'h0400_0013;
      28: t = 32'h0900_0000;
      29: t = 32'h1400_0000;
      30: t = 32'h2000_0029;
      31: t = 32'h4800_0000;
      32: t = 32'h8020_0003;
      default: t = 32'h0;
    endcase
    return t;
  endfunction
endpackage

// File: rtl/tpg_lfsr_step.sv
// tpg_lfsr_step: combinational Fibonacci LFSR next state.
module tpg_lfsr_step #(
  parameter int OUT_BITS = 4,
  parameter logic [OUT_BITS-1:0] TAPS = 4'b1100
) (
  input  logic [OUT_BITS-1:0] state_i,
  output logic [OUT_BITS-1:0] next_o
);
  assign next_o = {state_i[OUT_BITS-2:0], ^(state_i & TAPS)};
endmodule

// File: rtl/tpg_mode.sv
// tpg_mode: multi-mode bounded-run test pattern generator with valid/ready output.
module tpg_mode import tpg_pkg::*; #(
  parameter int OUT_BITS = 4,
  parameter int CNT_BITS = 16,
  parameter logic [OUT_BITS-1:0] TAPS = OUT_BITS'(default_taps(OUT_BITS)),
  parameter logic [OUT_BITS-1:0] SEED = OUT_BITS'(1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [1:0]          mode,
  input  logic                seed_load,
  input  logic [OUT_BITS-1:0] seed_in,
  input  logic [CNT_BITS-1:0] num_patterns,
  input  logic                ready,
  output logic [OUT_BITS-1:0] TEST_PATTERN,
  output logic                valid,
  output logic                busy,
  output logic                done,
  output logic [CNT_BITS-1:0] pattern_idx
);
  localparam logic [OUT_BITS-1:0] ONE = OUT_BITS'(1);
  tpg_state_e state_q;
  tpg_mode_e mode_q, mode_in;
  logic [OUT_BITS-1:0] seed_q, pat_q, lfsr_nxt, step_d, init_d, seed_fix;
  logic [CNT_BITS-1:0] num_q, idx_q;
  logic valid_q, done_q;
  tpg_lfsr_step #(.OUT_BITS(OUT_BITS), .TAPS(TAPS)) u_lfsr (.state_i(pat_q), .next_o(lfsr_nxt));
  // A zero seed would lock the LFSR, so it is replaced by 1.
  assign seed_fix = (seed_in == '0) ? ONE : seed_in;
  assign mode_in = tpg_mode_e'(mode);
  always_comb begin
    step_d = (mode_q == TPG_LFSR)  ? lfsr_nxt :
             (mode_q == TPG_COUNT) ? pat_q + ONE :
                                     {pat_q[OUT_BITS-2:0], pat_q[OUT_BITS-1]};
    init_d = (mode_in == TPG_LFSR)  ? (seed_load ? seed_fix : seed_q) :
             (mode_in == TPG_COUNT) ? '0 :
             (mode_in == TPG_WALK1) ? ONE : ~ONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mode_q  <= TPG_LFSR;
      num_q   <= '0;
      seed_q  <= SEED;
      pat_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (seed_load) seed_q <= seed_fix;
          if (start) begin
            mode_q <= mode_in;
            num_q  <= num_patterns;
            pat_q  <= init_d;
            idx_q  <= '0;
            if (num_patterns == '0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_RUN;
              valid_q <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (ready) begin
            if (idx_q == num_q - CNT_BITS'(1)) begin
              state_q <= ST_DONE;
              valid_q <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              pat_q <= step_d;
              idx_q <= idx_q + CNT_BITS'(1);
            end
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end
  assign TEST_PATTERN = pat_q;
  assign valid = valid_q;
  assign busy = valid_q;
  assign done = done_q;
  assign pattern_idx = idx_q;
endmodule

// File: tb/tb_tpg_mode.sv
// tb_tpg_mode: directed self-checking bench for tpg_mode.
module tb_tpg_mode;
  logic clk = 1'b0;
  logic rst = 1'b0, start = 1'b0, seed_load = 1'b0, ready = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [3:0] seed_in = 4'd0;
  logic [15:0] num = 16'd0;
  logic [3:0] tp;
  logic valid, busy, done;
  logic [15:0] idx;
  int checks = 0, errors = 0;
  localparam logic [3:0] LFSR_EXP [16] = '{4'd1, 4'd2, 4'd4, 4'd9, 4'd3, 4'd6, 4'd13, 4'd10,
                                          4'd5, 4'd11, 4'd7, 4'd15, 4'd14, 4'd12, 4'd8, 4'd1};
  localparam logic [3:0] WALK1_EXP [6] = '{4'd1, 4'd2, 4'd4, 4'd8, 4'd1, 4'd2};
  localparam logic [3:0] WALK0_EXP [3] = '{4'b1110, 4'b1101, 4'b1011};

  tpg_mode #(.OUT_BITS(4), .CNT_BITS(16), .TAPS(4'b1100), .SEED(4'd1)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .seed_load(seed_load),
    .seed_in(seed_in), .num_patterns(num), .ready(ready), .TEST_PATTERN(tp),
    .valid(valid), .busy(busy), .done(done), .pattern_idx(idx));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [1:0] m, input logic [15:0] n);
    mode = m;
    num = n;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (tp !== 4'd0 || valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || idx !== 16'd0) begin
      errors++;
      $display("FAIL reset: got pat=%h valid=%b busy=%b done=%b idx=%0d, want all 0", tp, valid, busy, done, idx);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_lfsr();
    ready = 1'b1;
    go(2'd0, 16'd5);
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (tp !== LFSR_EXP[k] || valid !== 1'b1 || busy !== 1'b1 || idx !== 16'(k) || done !== 1'b0) begin
        errors++;
        $display("FAIL lfsr5 k=%0d: got pat=%h valid=%b busy=%b idx=%0d done=%b, want pat=%h valid=1 busy=1 idx=%0d done=0",
                 k, tp, valid, busy, idx, done, LFSR_EXP[k], k);
      end
      tick();
    end
    checks++;
    if (done !== 1'b1 || valid !== 1'b0 || busy !== 1'b0 || tp !== 4'd3) begin
      errors++;
      $display("FAIL lfsr5_done: got done=%b valid=%b busy=%b pat=%h, want done=1 valid=0 busy=0 pat=3", done, valid, busy, tp);
    end
    tick();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL lfsr5_done_pulse: got done=%b, want 0", done);
    end
    go(2'd0, 16'd16);
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (tp !== LFSR_EXP[k] || valid !== 1'b1 || idx !== 16'(k)) begin
        errors++;
        $display("FAIL lfsr16 k=%0d: got pat=%h valid=%b idx=%0d, want pat=%h valid=1 idx=%0d", k, tp, valid, idx, LFSR_EXP[k], k);
      end
      tick();
    end
    checks++;
    if (done !== 1'b1 || valid !== 1'b0) begin
      errors++;
      $display("FAIL lfsr16_done: got done=%b valid=%b, want done=1 valid=0", done, valid);
    end
    tick();
  endtask

  task automatic test_counter();
    ready = 1'b1;
    go(2'd1, 16'd18);
    for (int k = 0; k < 18; k++) begin
      checks++;
      if (tp !== 4'(k % 16) || valid !== 1'b1 || idx !== 16'(k) || done !== 1'b0) begin
        errors++;
        $display("FAIL counter k=%0d: got pat=%h valid=%b idx=%0d done=%b, want pat=%h valid=1 idx=%0d done=0",
                 k, tp, valid, idx, done, 4'(k % 16), k);
      end
      tick();
    end
    checks++;
    if (done !== 1'b1 || valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL counter_done: got done=%b valid=%b busy=%b, want done=1 valid=0 busy=0", done, valid, busy);
    end
    tick();
  endtask

  task automatic test_walk();
    ready = 1'b0;
    go(2'd2, 16'd6);
    for (int c = 0; c < 12; c++) begin
      ready = (c % 2) == 1;
      checks++;
      if (tp !== WALK1_EXP[c/2] || valid !== 1'b1 || idx !== 16'(c/2)) begin
        errors++;
        $display("FAIL walk1 c=%0d: got pat=%h valid=%b idx=%0d, want pat=%h valid=1 idx=%0d", c, tp, valid, idx, WALK1_EXP[c/2], c/2);
      end
      tick();
    end
    checks++;
    if (done !== 1'b1 || valid !== 1'b0) begin
      errors++;
      $display("FAIL walk1_done: got done=%b valid=%b, want done=1 valid=0", done, valid);
    end
    tick();
    ready = 1'b1;
    go(2'd3, 16'd3);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (tp !== WALK0_EXP[k] || valid !== 1'b1) begin
        errors++;
        $display("FAIL walk0 k=%0d: got pat=%b valid=%b, want pat=%b valid=1", k, tp, valid, WALK0_EXP[k]);
      end
      tick();
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL walk0_done: got done=%b, want 1", done);
    end
    tick();
  endtask

  task automatic test_seed();
    ready = 1'b1;
    seed_load = 1'b1;
    seed_in = 4'd5;
    tick();
    seed_in = 4'd0;
    tick();
    seed_load = 1'b0;
    go(2'd0, 16'd4);
    for (int k = 0; k < 4; k++) begin
      if (k == 1) begin
        seed_load = 1'b1;
        seed_in = 4'hF;
      end
      checks++;
      if (tp !== LFSR_EXP[k] || valid !== 1'b1) begin
        errors++;
        $display("FAIL seed_zero k=%0d: got pat=%h valid=%b, want pat=%h valid=1", k, tp, valid, LFSR_EXP[k]);
      end
      tick();
      seed_load = 1'b0;
    end
    tick();
    go(2'd0, 16'd1);
    checks++;
    if (tp !== 4'd1) begin
      errors++;
      $display("FAIL seed_run_ignored: got pat=%h, want 1", tp);
    end
    tick();
    tick();
    seed_load = 1'b1;
    seed_in = 4'd9;
    go(2'd0, 16'd2);
    seed_load = 1'b0;
    checks++;
    if (tp !== 4'd9) begin
      errors++;
      $display("FAIL seed_same_cycle p0: got pat=%h, want 9", tp);
    end
    tick();
    checks++;
    if (tp !== 4'd3) begin
      errors++;
      $display("FAIL seed_same_cycle p1: got pat=%h, want 3", tp);
    end
    tick();
    tick();
  endtask

  task automatic test_zero();
    ready = 1'b1;
    go(2'd0, 16'd0);
    checks++;
    if (done !== 1'b1 || valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_done: got done=%b valid=%b busy=%b, want done=1 valid=0 busy=0", done, valid, busy);
    end
    tick();
    checks++;
    if (done !== 1'b0 || valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_after: got done=%b valid=%b busy=%b, want 0 0 0", done, valid, busy);
    end
    ready = 1'b0;
    go(2'd1, 16'd4);
    mode = 2'd2;
    num = 16'd9;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (tp !== 4'd0 || idx !== 16'd0 || valid !== 1'b1) begin
      errors++;
      $display("FAIL restart_ignored: got pat=%h idx=%0d valid=%b, want pat=0 idx=0 valid=1", tp, idx, valid);
    end
    ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (tp !== 4'(k) || idx !== 16'(k)) begin
        errors++;
        $display("FAIL restart_run k=%0d: got pat=%h idx=%0d, want pat=%h idx=%0d", k, tp, idx, 4'(k), k);
      end
      tick();
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL restart_done: got done=%b, want 1", done);
    end
    tick();
  endtask

  task automatic test_rst_mid();
    localparam logic [3:0] EXP9 [4] = '{4'd9, 4'd3, 4'd6, 4'd13};
    ready = 1'b1;
    go(2'd0, 16'd10);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (tp !== EXP9[k] || idx !== 16'(k)) begin
        errors++;
        $display("FAIL rst_mid k=%0d: got pat=%h idx=%0d, want pat=%h idx=%0d", k, tp, idx, EXP9[k], k);
      end
      if (k < 3) tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (tp !== 4'd0 || valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || idx !== 16'd0) begin
      errors++;
      $display("FAIL rst_abort: got pat=%h valid=%b busy=%b done=%b idx=%0d, want all 0", tp, valid, busy, done, idx);
    end
    tick();
    checks++;
    if (done !== 1'b0 || valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_no_done: got done=%b valid=%b, want 0 0", done, valid);
    end
    go(2'd0, 16'd2);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (tp !== LFSR_EXP[k] || valid !== 1'b1) begin
        errors++;
        $display("FAIL rst_restart k=%0d: got pat=%h valid=%b, want pat=%h valid=1", k, tp, valid, LFSR_EXP[k]);
      end
      tick();
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL rst_restart_done: got done=%b, want 1", done);
    end
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_lfsr();
    test_counter();
    test_walk();
    test_seed();
    test_zero();
    test_rst_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/tpg_mode.md
# tpg_mode

Multi-mode, parametrised test pattern generator for the LBIST datapath. Drives the circuit under test with a bounded run of patterns in one of four modes: pseudo-random LFSR, exhaustive count, walking-one, walking-zero. Run start is a start pulse; per-pattern flow is a valid/ready handshake; completion is a done pulse, so the BIST controller and response compactor can stall it. Supersedes the free-running single-mode generator.

## Interface
- OUT_BITS, 4: pattern width, ≥ 3.
- CNT_BITS, 16: width of the pattern counter and of num_patterns.
- TAPS, 4'b1100: LFSR feedback mask, OUT_BITS wide. The default is x^4+x^3+1.
- SEED, 1: reset value of the seed register. Must be nonzero.
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a run; sampled only in IDLE.
- mode  in  2  0 LFSR, 1 counter, 2 walking-one, 3 walking-zero; latched on start.
- seed_load  in  1  write seed_in to the seed register; honoured only in IDLE.
- seed_in  in  OUT_BITS  new LFSR seed.
- num_patterns  in  CNT_BITS  run length; latched on start.
- ready  in  1  downstream accepts TEST_PATTERN this cycle.
- TEST_PATTERN  out  OUT_BITS  registered pattern.
- valid  out  1  TEST_PATTERN holds a pattern.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse at end of run.
- pattern_idx  out  CNT_BITS  index of the pattern currently presented.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - seed_load writes seed_in to the seed register. If seed_in is 0, the register stores 1 (prevents LFSR lock-up).
  - On start, latch mode and num_patterns, load the generator, clear pattern_idx.
  - Go to RUN, or go straight to DONE if num_patterns == 0.
- Generator initial value by mode:
  - LFSR: seed register.
  - Counter: 0.
  - Walking-one: 1.
  - Walking-zero: ~1.
- seed_load and start in the same cycle: the new seed is the one used.
- Generator step by mode:
  - LFSR (Fibonacci): next = {s[OUT_BITS-2:0], ^(s & TAPS)}.
  - Counter: s+1, wrapping modulo 2^OUT_BITS.
  - Walking-one / walking-zero: rotate left by 1.
- RUN:
  - valid = 1, and TEST_PATTERN = generator state.
  - When valid && ready, advance the generator and increment pattern_idx.
  - If the handshake accepts pattern num_patterns-1, go to DONE and deassert valid.
  - When ready = 0, TEST_PATTERN and pattern_idx hold.
- DONE: done = 1 for exactly one cycle, then IDLE. TEST_PATTERN keeps the last value.
- start, seed_load, and changes to mode/num_patterns outside IDLE are ignored.

## Timing
- Reset values: state IDLE, TEST_PATTERN 0, valid 0, busy 0, done 0, pattern_idx 0, seed register SEED.
- rst asserted mid-run aborts the run in the next cycle. No done is issued.
- start sampled at cycle t gives valid = 1 with pattern 0 at t+1.
- With ready held high, one pattern per cycle: pattern k at t+1+k.
- With ready held high, done is high at t+1+num_patterns.
- With num_patterns == 0, done is high at t+1, valid never asserts, busy stays 0.
- busy equals valid. Both drop the same cycle done rises.
- Earliest restart: start may be sampled in the cycle after done.
- Max run length: 2^CNT_BITS-1 patterns. The pattern sequence may wrap within a run; this is legal.

## Structure
- Package tpg_pkg holds:
  - the mode enum (TPG_LFSR, TPG_COUNT, TPG_WALK1, TPG_WALK0);
  - the FSM state typedef;
  - a function returning default maximal-length TAPS for OUT_BITS 3–32.
- Sub-module tpg_lfsr_step: purely combinational next-state for the LFSR, parametrised on OUT_BITS and TAPS.
- The counter and rotate steps stay inline in the top level, selected by the latched mode.

## Test plan
- LFSR run: OUT_BITS=4, TAPS=1100, seed 0001, num_patterns=5, ready high.
  - Required: TEST_PATTERN 1,2,4,9,3 on consecutive cycles, then a single-cycle done.
  - Extended run of 16: pattern 15 equals pattern 0 (period 15).
- Counter mode, num_patterns=18, ready high.
  - Required: 0..15, 0, 1 (wraps), pattern_idx 0..17, done one cycle after pattern_idx=17.
- Walking-one, num_patterns=6, ready toggled 1,0,1,0,…
  - Required: 1,2,4,8,1,2, each held for 2 cycles; no pattern skipped or duplicated across handshakes.
- seed_load with seed_in=0, then LFSR start.
  - Required: first pattern 0001.
  - A seed_load during RUN does not change the sequence.
- num_patterns=0.
  - Required: done one cycle after start, valid never high.
  - A second start while in RUN is ignored; pattern_idx unaffected.
- rst at pattern 3 of a 10-pattern run.
  - Required: next cycle all outputs 0 and no done.
  - A new start then begins again from the seed register.
